button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and condition one raw push-button for the alarm-clock PIO, with long-press and auto-repeat.
// Latency: a clean level change reaches btn_out/pressed/press_pulse DEBOUNCE_CYCLES+3 rising edges after it is first sampled.
// Backpressure: none; the raw pin cannot be stalled, so every output is a free-running registered level or pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  input  logic repeat_en,
  output logic btn_out,
  output logic pressed,
  output logic press_pulse,
  output logic long_press
);

  // Terminal counts for the three 32-bit timers.
  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

  // Raw pin level while the button is not pressed.
  localparam logic RELEASED_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Auto-repeat gap sequencer: btn_out is high for GAP_FIRST and GAP_SECOND.
  typedef enum logic [1:0] {
    GAP_NONE   = 2'd0,
    GAP_FIRST  = 2'd1,
    GAP_SECOND = 2'd2
  } gap_t;

  logic        sync_q1;
  logic        sync_q2;
  logic        p;
  state_t      state;
  gap_t        gap;
  logic [31:0] cnt;
  logic [31:0] hold_cnt;
  logic [31:0] rep_cnt;

  // Two-flop synchroniser on the asynchronous pin, parked at the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= RELEASED_LVL;
      sync_q2 <= RELEASED_LVL;
    end else begin
      sync_q1 <= button_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Normalised pressed bit: 1 means the button is physically pressed.
  assign p = sync_q2 ^ ACTIVE_LOW;

  // Debounce / hold / auto-repeat state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gap         <= GAP_NONE;
      cnt         <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      btn_out     <= 1'b1;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      // press_pulse is a single-cycle strobe unless re-armed below.
      press_pulse <= 1'b0;

      case (state)
        IDLE: begin
          btn_out <= 1'b1;
          if (p) begin
            state <= DB_PRESS;
            cnt   <= '0;
          end
        end

        DB_PRESS: begin
          if (!p) begin
            // Glitch shorter than the debounce window: drop it silently.
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state       <= HELD;
            btn_out     <= 1'b0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            gap         <= GAP_NONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        HELD: begin
          if (!p) begin
            // Start release debounce; an unfinished repeat gap is abandoned
            // so btn_out stays low until the release is accepted.
            state   <= DB_RELEASE;
            cnt     <= '0;
            gap     <= GAP_NONE;
            btn_out <= 1'b0;
          end else begin
            // Hold timer saturates at its terminal count and latches long_press.
            if (hold_cnt == LONG_LAST) begin
              long_press <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 32'd1;
            end

            // Repeat period timer only runs once long-pressed with repeat enabled.
            if (!repeat_en) begin
              rep_cnt <= '0;
            end else if (long_press) begin
              if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 32'd1;
              end
            end

            // Synthetic release/press: two cycles high, then low with a pulse.
            // A started gap always completes even if repeat_en drops meanwhile.
            case (gap)
              GAP_NONE: begin
                if (long_press && repeat_en && (rep_cnt == REP_LAST)) begin
                  btn_out <= 1'b1;
                  gap     <= GAP_FIRST;
                end
              end
              GAP_FIRST: begin
                gap <= GAP_SECOND;
              end
              GAP_SECOND: begin
                btn_out     <= 1'b0;
                press_pulse <= 1'b1;
                gap         <= GAP_NONE;
              end
              default: begin
                gap <= GAP_NONE;
              end
            endcase
          end
        end

        DB_RELEASE: begin
          btn_out <= 1'b0;
          if (p) begin
            // Bounce: resume HELD with hold/repeat timers as they were.
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state      <= IDLE;
            btn_out    <= 1'b1;
            pressed    <= 1'b0;
            long_press <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose: directed self-checking bench for button_conditioner with an event scoreboard and a PIO edge-capture model.
// Latency: expected output edges are scheduled at absolute clock-edge numbers derived from the debounce/hold/repeat timing.
// Backpressure: none; stimulus is a linear sequence of timed pin levels.
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int LG  = 20;
  localparam int RP  = 8;
  localparam int LAT = DB + 3;

  logic clk;
  logic reset;
  logic button_raw;
  logic repeat_en;
  logic btn_out;
  logic pressed;
  logic press_pulse;
  logic long_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .REPEAT_CYCLES  (RP),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .repeat_en  (repeat_en),
    .btn_out    (btn_out),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .long_press (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   at;
    logic val;
  } ev_t;

  // Scoreboard queues of expected output changes, in chronological order.
  ev_t q_btn[$];
  ev_t q_prs[$];
  ev_t q_pul[$];
  ev_t q_lng[$];

  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   cap_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_btn = 1'b1;
  logic prev_prs = 1'b0;
  logic prev_lng = 1'b0;
  logic pio_d0;
  logic pio_d1;

  // Per-press bookkeeping shared between press and release steps.
  int   cap0;
  int   n_gaps;
  logic long_set;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising-edge counter used to time-stamp every observed output change.
  always @(posedge clk) edge_n <= edge_n + 1;

  // Model of the PIO in_port falling-edge capture (two flops on btn_out).
  always @(posedge clk) begin
    pio_d0 <= btn_out;
    pio_d1 <= pio_d0;
    if (pio_d1 === 1'b1 && pio_d0 === 1'b0) cap_cnt <= cap_cnt + 1;
  end

  // Monitor: every output change must match the head of its scoreboard queue.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (btn_out !== prev_btn) begin
        check("btn_expected", 32'(q_btn.size() > 0), 32'd1);
        if (q_btn.size() > 0) begin
          e = q_btn.pop_front();
          check("btn_edge", 32'(edge_n), 32'(e.at));
          check("btn_val", 32'(btn_out), 32'(e.val));
        end
      end
      if (pressed !== prev_prs) begin
        check("pressed_expected", 32'(q_prs.size() > 0), 32'd1);
        if (q_prs.size() > 0) begin
          e = q_prs.pop_front();
          check("pressed_edge", 32'(edge_n), 32'(e.at));
          check("pressed_val", 32'(pressed), 32'(e.val));
        end
      end
      if (press_pulse !== 1'b0) begin
        check("pulse_expected", 32'(q_pul.size() > 0), 32'd1);
        if (q_pul.size() > 0) begin
          e = q_pul.pop_front();
          check("pulse_edge", 32'(edge_n), 32'(e.at));
          check("pulse_val", 32'(press_pulse), 32'(e.val));
        end
      end
      if (long_press !== prev_lng) begin
        check("long_expected", 32'(q_lng.size() > 0), 32'd1);
        if (q_lng.size() > 0) begin
          e = q_lng.pop_front();
          check("long_edge", 32'(edge_n), 32'(e.at));
          check("long_val", 32'(long_press), 32'(e.val));
        end
      end
    end
    prev_btn = btn_out;
    prev_prs = pressed;
    prev_lng = long_press;
  end

  task automatic check_drained(input string tag);
    check({tag, "_btn_left"},   32'(q_btn.size()), 32'd0);
    check({tag, "_prs_left"},   32'(q_prs.size()), 32'd0);
    check({tag, "_pulse_left"}, 32'(q_pul.size()), 32'd0);
    check({tag, "_long_left"},  32'(q_lng.size()), 32'd0);
  endtask

  // Press the button at the current falling edge and hold it for 'hold' cycles.
  task automatic do_press(input int hold, input logic ren);
    int t0, t1, f, lr;
    repeat_en  = ren;
    cap0       = cap_cnt;
    button_raw = 1'b0;
    t0 = edge_n;
    t1 = t0 + hold;
    f  = t0 + LAT;
    lr = f + LG;
    q_btn.push_back('{f, 1'b0});
    q_prs.push_back('{f, 1'b1});
    q_pul.push_back('{f, 1'b1});
    long_set = 1'b0;
    // The last HELD edge that still sees the pin pressed is t1+2.
    if (lr <= t1 + 2) begin
      q_lng.push_back('{lr, 1'b1});
      long_set = 1'b1;
    end
    n_gaps = 0;
    if (ren) begin
      for (int g = lr + RP; g <= t1; g += RP) begin
        q_btn.push_back('{g, 1'b1});
        q_btn.push_back('{g + 2, 1'b0});
        q_pul.push_back('{g + 2, 1'b1});
        n_gaps++;
      end
    end
    repeat (hold) @(negedge clk);
  endtask

  // Release the button and let the release debounce complete.
  task automatic do_release(input string tag);
    int t1;
    button_raw = 1'b1;
    t1 = edge_n;
    q_btn.push_back('{t1 + LAT, 1'b1});
    q_prs.push_back('{t1 + LAT, 1'b0});
    if (long_set) q_lng.push_back('{t1 + LAT, 1'b0});
    repeat (LAT + 6) @(negedge clk);
    check({tag, "_pio_captures"}, 32'(cap_cnt - cap0), 32'(1 + n_gaps));
    check({tag, "_btn_idle"}, 32'(btn_out), 32'd1);
    check_drained(tag);
  endtask

  initial begin
    int tr;
    reset      = 1'b1;
    button_raw = 1'b1;
    repeat_en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset_btn_out", 32'(btn_out), 32'd1);
    check("reset_pressed", 32'(pressed), 32'd0);
    check("reset_pulse",   32'(press_pulse), 32'd0);
    check("reset_long",    32'(long_press), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle with the button released.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_btn_out", 32'(btn_out), 32'd1);
      check("idle_pulse",   32'(press_pulse), 32'd0);
    end

    // Clean press held 30 cycles, then release.
    do_press(30, 1'b0);
    do_release("press30");

    // Bounce shorter than the debounce window is rejected.
    for (int i = 0; i < 5; i++) begin
      button_raw = 1'b0;
      repeat (3) @(negedge clk);
      button_raw = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("bounce_btn_out", 32'(btn_out), 32'd1);
    check("bounce_pressed", 32'(pressed), 32'd0);
    check_drained("bounce");

    // Long hold without auto-repeat.
    do_press(60, 1'b0);
    do_release("hold60_norep");

    // Long hold with auto-repeat.
    do_press(60, 1'b1);
    check("repeat_gap_count", 32'(n_gaps), 32'd4);
    do_release("hold60_rep");
    repeat_en = 1'b0;

    // Reset while held with long_press set.
    repeat (5) @(negedge clk);
    do_press(30, 1'b0);
    check("pre_reset_long", 32'(long_press), 32'd1);
    reset      = 1'b1;
    button_raw = 1'b1;
    tr = edge_n;
    q_btn.push_back('{tr + 1, 1'b1});
    q_prs.push_back('{tr + 1, 1'b0});
    q_lng.push_back('{tr + 1, 1'b0});
    @(negedge clk);
    check("midreset_btn_out", 32'(btn_out), 32'd1);
    check("midreset_long",    32'(long_press), 32'd0);
    check("midreset_pulse",   32'(press_pulse), 32'd0);
    check("midreset_pressed", 32'(pressed), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_drained("midreset");

    // A fresh press after the reset behaves normally.
    do_press(30, 1'b0);
    do_release("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
